// File: rtl/ti_nibble_unmasker.sv
// Threshold-implementation output stage: refreshes shared S-box nibbles, recombines them
// behind a register boundary and packs the unmasked nibbles into one frame word.
module ti_nibble_unmasker #(
  parameter int NSHARE  = 4,
  parameter int SHARE_W = 4,
  parameter int NIBBLES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [NSHARE*SHARE_W-1:0]     s_shares,
  input  logic                          s_last,
  input  logic [(NSHARE-1)*SHARE_W-1:0] rnd,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [NIBBLES*SHARE_W-1:0]    m_data,
  output logic                          m_err
);
  localparam int SH_W  = NSHARE * SHARE_W;
  localparam int PAD_W = (NSHARE + 1) * SHARE_W;
  localparam int ACC_W = NIBBLES * SHARE_W;
  localparam int CNT_W = $clog2(NIBBLES) + 1;

  typedef enum logic {COLLECT = 1'b0, OUT = 1'b1} state_t;
  state_t state_q, state_d;

  logic [SH_W-1:0]    st1_sh_q, st1_sh_d;
  logic               st1_v_q, st1_last_q;
  logic [SHARE_W-1:0] st2_nib_q, st2_nib_d;
  logic               st2_v_q, st2_last_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               err_q;
  logic [PAD_W-1:0]   rnd_pad;
  logic               in_hs, out_hs, acc_take, st2_load, cnt_full, frame_close;

  assign acc_take    = st2_v_q && (state_q == COLLECT);
  assign st2_load    = st1_v_q && (!st2_v_q || acc_take);
  assign s_ready     = !st1_v_q || st2_load;
  assign in_hs       = s_valid && s_ready;
  assign out_hs      = m_valid && m_ready;
  assign cnt_full    = (cnt_q == CNT_W'(NIBBLES - 1));
  assign frame_close = acc_take && (st2_last_q || cnt_full);

  // Zero guard shares at both ends let every share use r_(i-1) ^ r_i uniformly.
  assign rnd_pad = {{SHARE_W{1'b0}}, rnd, {SHARE_W{1'b0}}};

  always_comb begin : refresh
    st1_sh_d = '0;
    for (int i = 0; i < NSHARE; i++) begin
      st1_sh_d[i*SHARE_W +: SHARE_W] = s_shares[i*SHARE_W +: SHARE_W]
                                     ^ rnd_pad[i*SHARE_W +: SHARE_W]
                                     ^ rnd_pad[(i+1)*SHARE_W +: SHARE_W];
    end
  end

  always_comb begin : recombine
    st2_nib_d = '0;
    for (int i = 0; i < NSHARE; i++) begin
      st2_nib_d = st2_nib_d ^ st1_sh_q[i*SHARE_W +: SHARE_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin : pipe
    if (rst) begin
      st1_sh_q   <= '0;
      st1_last_q <= 1'b0;
      st1_v_q    <= 1'b0;
      st2_nib_q  <= '0;
      st2_last_q <= 1'b0;
      st2_v_q    <= 1'b0;
    end else begin
      if (in_hs) begin
        st1_sh_q   <= st1_sh_d;
        st1_last_q <= s_last;
        st1_v_q    <= 1'b1;
      end else if (st2_load) begin
        st1_v_q <= 1'b0;
      end
      if (st2_load) begin
        st2_nib_q  <= st2_nib_d;
        st2_last_q <= st1_last_q;
        st2_v_q    <= 1'b1;
      end else if (acc_take) begin
        st2_v_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin : accum
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (out_hs) begin
      acc_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (acc_take) begin
      acc_q <= {acc_q[ACC_W-SHARE_W-1:0], st2_nib_q};
      cnt_q <= cnt_q + CNT_W'(1);
      if (frame_close) err_q <= (st2_last_q != cnt_full);
    end
  end

  always_ff @(posedge clk or posedge rst) begin : state_reg
    if (rst) state_q <= COLLECT;
    else     state_q <= state_d;
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      COLLECT: if (frame_close) state_d = OUT;
      OUT:     if (m_ready)     state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  always_comb begin : outputs
    m_valid = (state_q == OUT);
    m_data  = (state_q == OUT) ? acc_q : '0;
    m_err   = err_q;
  end

endmodule

// File: tb/tb_ti_nibble_unmasker.sv
// Self-checking bench for ti_nibble_unmasker: frame table, hand sequences for latency,
// back-pressure and reset, plus random traffic against a frame-level reference model.
module tb_ti_nibble_unmasker;
  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid, s_ready, s_last;
  logic [15:0] s_shares;
  logic [11:0] rnd;
  logic        m_valid, m_ready, m_err;
  logic [63:0] m_data;

  ti_nibble_unmasker #(.NSHARE(4), .SHARE_W(4), .NIBBLES(16)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_shares(s_shares), .s_last(s_last), .rnd(rnd),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_err(m_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Reference model: nibbles collected per frame, closed by last or by reaching 16.
  logic [3:0]  cur_q[$];
  logic [63:0] exp_data[$];
  logic        exp_err[$];

  task automatic model_push(input logic [3:0] nib, input bit last);
    logic [63:0] d;
    cur_q.push_back(nib);
    if (last || cur_q.size() == 16) begin
      d = '0;
      foreach (cur_q[k]) d = (d << 4) | 64'(cur_q[k]);
      exp_data.push_back(d);
      exp_err.push_back(!(last && cur_q.size() == 16));
      cur_q.delete();
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output monitor: scoreboard on handshakes, stability while stalled, pulse timing.
  logic [63:0] prev_data, last_out_data, ed;
  logic        prev_v = 1'b0, prev_r = 1'b0, prev_err, last_out_err, ee;
  int          rise_edge = 0, hs_edge = 0, run = 0, last_run = 0;

  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      prev_v = 1'b0;
      run = 0;
    end else begin
      if (prev_v && !prev_r) begin
        chk("hold_valid", 64'(m_valid), 64'd1);
        if (m_valid) begin
          chk("hold_data", m_data, prev_data);
          chk("hold_err", 64'(m_err), 64'(prev_err));
        end
      end
      if (m_valid && !prev_v) rise_edge = cyc;
      if (m_valid) run++;
      else if (run > 0) begin last_run = run; run = 0; end
      if (m_valid && m_ready) begin
        if (exp_data.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_frame: got data %h with no frame expected", m_data);
        end else begin
          ed = exp_data.pop_front();
          ee = exp_err.pop_front();
          chk("frame_data", m_data, ed);
          chk("frame_err", 64'(m_err), 64'(ee));
        end
        last_out_data = m_data;
        last_out_err  = m_err;
      end
      prev_v = m_valid; prev_r = m_ready; prev_data = m_data; prev_err = m_err;
    end
  end

  // Called at a negedge; returns at the negedge following the handshake edge.
  task automatic send(input logic [3:0] nib, input bit last, input bit fixed);
    logic [3:0]  s1, s2, s3, nv;
    logic [15:0] sh;
    logic [11:0] r;
    int guard;
    s1 = 4'($urandom); s2 = 4'($urandom); s3 = 4'($urandom);
    sh = fixed ? 16'hC530 : {s3, s2, s1, nib ^ s1 ^ s2 ^ s3};
    nv = fixed ? 4'hA : nib;
    r  = 12'($urandom);
    s_shares = sh; rnd = r; s_last = last; s_valid = 1'b1;
    guard = 0;
    while (!s_ready && guard < 300) begin @(negedge clk); guard++; end
    if (guard >= 300) begin
      checks++; errors++;
      $display("FAIL send_timeout: s_ready stayed 0 for %0d cycles", guard);
    end else begin
      @(negedge clk);
      hs_edge = cyc;
      chk("st1_share0", 64'(dut.st1_sh_q[3:0]), 64'(sh[3:0] ^ r[3:0]));
      model_push(nv, last);
    end
    s_valid = 1'b0; s_last = 1'b0;
    s_shares = 16'($urandom); rnd = 12'($urandom);
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (exp_data.size() != 0 && guard < 3000) begin @(negedge clk); guard++; end
    if (guard >= 3000) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d frames still expected", exp_data.size());
    end
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    int          len;
    bit          last;
    logic [3:0]  first;
    logic [63:0] exp_data;
    bit          exp_err;
  } frame_vec_t;
  frame_vec_t tbl[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  bit done, saw_stall;

  initial begin
    tbl[0] = '{16, 1'b1, 4'h0, 64'h0123456789ABCDEF, 1'b0};
    tbl[1] = '{ 5, 1'b1, 4'h1, 64'h0000000000012345, 1'b1};
    tbl[2] = '{16, 1'b1, 4'h8, 64'h89ABCDEF01234567, 1'b0};
    tbl[3] = '{16, 1'b0, 4'h3, 64'h3456789ABCDEF012, 1'b1};
    tbl[4] = '{ 1, 1'b1, 4'hC, 64'h000000000000000C, 1'b1};
    tbl[5] = '{15, 1'b1, 4'hF, 64'h0F0123456789ABCD, 1'b1};

    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_shares = '0; rnd = '0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data", m_data, 64'd0);
    chk("rst_m_err", 64'(m_err), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single frame: latency and one-cycle valid pulse.
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(4'(i), i == 15, 1'b0);
    wait_drain();
    chk("latency_edges", 64'(rise_edge - hs_edge), 64'd2);
    chk("valid_pulse_len", 64'(last_run), 64'd1);
    chk("single_data", last_out_data, 64'h0123456789ABCDEF);
    chk("single_err", 64'(last_out_err), 64'd0);

    foreach (tbl[t]) begin
      for (int k = 0; k < tbl[t].len; k++)
        send(tbl[t].first + 4'(k), tbl[t].last && (k == tbl[t].len - 1), 1'b0);
      wait_drain();
      chk($sformatf("tbl%0d_data", t), last_out_data, tbl[t].exp_data);
      chk($sformatf("tbl%0d_err", t), 64'(last_out_err), 64'(tbl[t].exp_err));
    end

    // Back-pressure: frame 2 streams while frame 1 is held for 10 cycles.
    m_ready = 1'b0;
    saw_stall = 1'b0;
    fork
      begin
        for (int i = 0; i < 16; i++) send(4'(i), i == 15, 1'b0);
        for (int i = 0; i < 16; i++) send(4'(15 - i), i == 15, 1'b0);
      end
      begin
        int g = 0;
        while (!m_valid && g < 200) begin @(negedge clk); g++; end
        if (g >= 200) begin
          checks++; errors++;
          $display("FAIL bp_valid_timeout: m_valid never rose");
        end
        repeat (10) begin
          @(negedge clk);
          if (!s_ready) saw_stall = 1'b1;
        end
        chk("bp_held_data", m_data, 64'h0123456789ABCDEF);
        m_ready = 1'b1;
      end
    join
    wait_drain();
    chk("bp_s_ready_dropped", 64'(saw_stall), 64'd1);
    chk("bp_frame2_data", last_out_data, 64'hFEDCBA9876543210);

    // Refresh invariance: fixed shares of 0xA with 4096 random masks.
    for (int f = 0; f < 256; f++)
      for (int k = 0; k < 16; k++) send(4'h0, k == 15, 1'b1);
    wait_drain();
    chk("refresh_data", last_out_data, {16{4'hA}});

    // Random traffic with random back-pressure.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 400; i++) send(4'($urandom), $urandom_range(0, 7) == 0, 1'b0);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          m_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    m_ready = 1'b1;
    send(4'($urandom), 1'b1, 1'b0);
    wait_drain();

    // Reset mid-frame, between edges.
    for (int i = 0; i < 7; i++) send(4'(i + 3), 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_m_valid", 64'(m_valid), 64'd0);
    chk("midrst_m_data", m_data, 64'd0);
    chk("midrst_m_err", 64'(m_err), 64'd0);
    chk("midrst_s_ready", 64'(s_ready), 64'd1);
    cur_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) send(4'(15 - i), i == 15, 1'b0);
    wait_drain();
    chk("post_rst_data", last_out_data, 64'hFEDCBA9876543210);
    chk("post_rst_err", 64'(last_out_err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
